iobus_master: RTL and testbench

Command-driven initiator for the OTTER memory-mapped IOBUS, the counterpart to the wrapper-side peripheral decoder. It accepts read/write commands on a valid/ready interface from a host-side agent (serial programmer or debug bridge), requests the bus from the wrapper's arbiter, and drives IOBUS address, data and write strobe exactly as the MCU does. Read data and write acknowledgements return on a valid/ready response channel. It lets a host poke LEDs and the seven-segment display, or read switches and the cycle counter, while the MCU is held off the bus.

---
 rtl/iobus_pkg.sv | 23 ++
 rtl/iobus_master.sv | 145 ++++++++++++++
 tb/tb_iobus_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iobus_pkg.sv
// rtl/iobus_pkg.sv - shared FSM states, IOBUS address map and response type for iobus_master
package iobus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    RSP,
    DONE
  } state_t;

  localparam logic [31:0] SWITCHES = 32'h1100_0000;
  localparam logic [31:0] LEDS     = 32'h1108_0000;
  localparam logic [31:0] SSEG     = 32'h110C_0000;
  localparam logic [31:0] CLKCNTLO = 32'h1140_0000;
  localparam logic [31:0] CLKCNTHI = 32'h1140_0004;

  typedef struct packed {
    logic [31:0] rdata;
    logic        last;
  } rsp_t;

endpackage

// File: rtl/iobus_master.sv
// rtl/iobus_master.sv - command-driven OTTER IOBUS initiator; bursts enabled by IOBUS_MASTER_BURST_EN
module iobus_master
  import iobus_pkg::*;
#(
  parameter int ADDR_STEP = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  input  logic [7:0]  CMD_LEN,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_LAST,
  output logic        BUS_REQ,
  input  logic        BUS_GNT,
  output logic [31:0] IOBUS_ADDR,
  output logic [31:0] IOBUS_OUT,
  input  logic [31:0] IOBUS_IN,
  output logic        IOBUS_WR
);

  state_t      state, state_nx;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        last_beat;
  logic        accept;
  logic        beat;
  rsp_t        rsp;

  assign accept = (state == IDLE) && CMD_VALID;
  // A beat only completes in a granted XFER cycle; a lost grant stalls in place.
  assign beat   = (state == XFER) && BUS_GNT;

`ifdef IOBUS_MASTER_BURST_EN
  logic [7:0] cnt_q;

  assign last_beat = (cnt_q == 8'd0);

  // Beats remaining: loaded on accept, stepped per write strobe or per accepted non-final read response
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= 8'd0;
    end else if (accept) begin
      cnt_q <= CMD_LEN;
    end else if (beat && wr_q && !last_beat) begin
      cnt_q <= cnt_q - 8'd1;
    end else if ((state == RSP) && RSP_READY && !wr_q && !last_beat) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end
`else
  logic unused_cfg;

  assign last_beat  = 1'b1;
  assign unused_cfg = ^{CMD_LEN, 32'(ADDR_STEP)};
`endif

  // Bus address: loaded on accept, advanced after every completed beat (wraps modulo 2^32)
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q <= 32'd0;
    end else if (accept) begin
      addr_q <= CMD_ADDR;
`ifdef IOBUS_MASTER_BURST_EN
    end else if (beat) begin
      addr_q <= addr_q + 32'(ADDR_STEP);
`endif
    end
  end

  // Command fields and read capture; a write beat clears the data so its ack reads back 0
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else if (accept) begin
      wr_q    <= CMD_WR;
      wdata_q <= CMD_WDATA;
    end else if (beat) begin
      rdata_q <= wr_q ? 32'd0 : IOBUS_IN;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_nx   = state;
    CMD_READY  = 1'b0;
    BUS_REQ    = 1'b0;
    RSP_VALID  = 1'b0;
    IOBUS_WR   = 1'b0;
    rsp.rdata  = rdata_q;
    rsp.last   = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so the port reads 0 while reset is held.
        CMD_READY = RESET_N;
        if (CMD_VALID) state_nx = REQ;
      end
      REQ: begin
        BUS_REQ = 1'b1;
        if (BUS_GNT) state_nx = XFER;
      end
      XFER: begin
        BUS_REQ  = 1'b1;
        IOBUS_WR = wr_q && BUS_GNT;
        if (BUS_GNT && (!wr_q || last_beat)) state_nx = RSP;
      end
      RSP: begin
        BUS_REQ   = 1'b1;
        RSP_VALID = 1'b1;
        rsp.last  = wr_q || last_beat;
        if (RSP_READY) state_nx = (!wr_q && !last_beat) ? XFER : DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign RSP_RDATA  = rsp.rdata;
  assign RSP_LAST   = rsp.last;
  assign IOBUS_ADDR = addr_q;
  assign IOBUS_OUT  = wdata_q;

endmodule

// File: tb/tb_iobus_master.sv
// tb/tb_iobus_master.sv - scoreboard bench for iobus_master (default and IOBUS_MASTER_BURST_EN builds)
module tb_iobus_master;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WR = 1'b0;
  logic [31:0] CMD_ADDR = 32'd0;
  logic [31:0] CMD_WDATA = 32'd0;
  logic [7:0]  CMD_LEN = 8'd0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b1;
  logic [31:0] RSP_RDATA;
  logic        RSP_LAST;
  logic        BUS_REQ;
  logic        BUS_GNT = 1'b1;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic [31:0] IOBUS_IN;
  logic        IOBUS_WR;

  iobus_master #(.ADDR_STEP(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_LEN(CMD_LEN),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_LAST(RSP_LAST),
    .BUS_REQ(BUS_REQ), .BUS_GNT(BUS_GNT),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_IN(IOBUS_IN), .IOBUS_WR(IOBUS_WR)
  );

  always #5 CLK = ~CLK;

  // Peripheral model: fixed values for switches and cycle counter, address pattern elsewhere
  always_comb begin
    case (IOBUS_ADDR)
      32'h1100_0000: IOBUS_IN = 32'h0000_1234;
      32'h1140_0000: IOBUS_IN = 32'hC0DE_0001;
      32'h1140_0004: IOBUS_IN = 32'hC0DE_0002;
      default:       IOBUS_IN = IOBUS_ADDR ^ 32'hA5A5_A5A5;
    endcase
  end

  typedef struct {
    logic [31:0] rdata;
    logic        last;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] strb_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        stall_q = 1'b0;
  logic [32:0] stall_v = 33'd0;

`ifdef IOBUS_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Response monitor: pop the scoreboard on every accepted response
  always @(negedge CLK) begin
    if (RESET_N && RSP_VALID && RSP_READY) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got %h/%0b expected none", RSP_RDATA, RSP_LAST);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", RSP_RDATA, e.rdata);
        check("rsp_last", RSP_LAST, e.last);
        if (e.lat >= 0) check("rsp_latency", cyc - acc_cyc, e.lat);
      end
    end
  end

  // A stalled response must not change until accepted
  always @(negedge CLK) begin
    if (RESET_N && RSP_VALID) begin
      if (stall_q) check("rsp_hold", {RSP_RDATA, RSP_LAST}, stall_v);
      stall_q <= !RSP_READY;
      stall_v <= {RSP_RDATA, RSP_LAST};
    end else begin
      stall_q <= 1'b0;
    end
  end

  // Write strobe monitor: every strobe needs grant and must match the next expected beat
  always @(negedge CLK) begin
    if (RESET_N && IOBUS_WR) begin
      check("wr_needs_gnt", BUS_GNT, 1'b1);
      if (strb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got %h/%h expected none", IOBUS_ADDR, IOBUS_OUT);
      end else begin
        logic [63:0] s;
        s = strb_q.pop_front();
        check("strobe", {IOBUS_ADDR, IOBUS_OUT}, s);
      end
    end
  end

  task automatic push_rsp(input logic [31:0] rdata, input logic last, input int lat);
    exp_t e;
    e.rdata = rdata;
    e.last  = last;
    e.lat   = lat;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] len);
    int n = 0;
    @(posedge CLK); #1;
    CMD_VALID = 1'b1;
    CMD_WR    = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = wdata;
    CMD_LEN   = len;
    @(negedge CLK);
    while (!CMD_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("cmd_ready_wait", CMD_READY, 1'b1);
    @(posedge CLK); #1;
    acc_cyc   = cyc;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge CLK);
    while ((exp_q.size() != 0 || !CMD_READY) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_done"}, exp_q.size(), 0);
    check({name, "_strobes_left"}, strb_q.size(), 0);
  endtask

  task automatic wait_rsp_valid(input string name);
    int n = 0;
    @(negedge CLK);
    while (!RSP_VALID && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_rsp_valid"}, RSP_VALID, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, CMD_READY, 1'b0);
    check({tag, "_rsp_valid"}, RSP_VALID, 1'b0);
    check({tag, "_rsp_rdata"}, RSP_RDATA, 32'd0);
    check({tag, "_rsp_last"}, RSP_LAST, 1'b0);
    check({tag, "_bus_req"}, BUS_REQ, 1'b0);
    check({tag, "_iobus_addr"}, IOBUS_ADDR, 32'd0);
    check({tag, "_iobus_out"}, IOBUS_OUT, 32'd0);
    check({tag, "_iobus_wr"}, IOBUS_WR, 1'b0);
  endtask

  initial begin
    #23;
    check_reset_outputs("reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("idle_cmd_ready", CMD_READY, 1'b1);

    // Single write to LEDS: one strobe, ack with rdata 0, response in cycle 3
    strb_q.push_back({32'h1108_0000, 32'h0000_A5A5});
    push_rsp(32'd0, 1'b1, 2);
    issue(1'b1, 32'h1108_0000, 32'h0000_A5A5, 8'd0);
    wait_done("wr_leds");

    // Single read of SWITCHES; no strobe expected
    push_rsp(32'h0000_1234, 1'b1, 2);
    issue(1'b0, 32'h1100_0000, 32'hFFFF_FFFF, 8'd0);
    wait_done("rd_switches");

    // Two-beat read of the cycle counter with beat 0 back-pressured for 3 cycles
    if (BURST) begin
      push_rsp(32'hC0DE_0001, 1'b0, -1);
      push_rsp(32'hC0DE_0002, 1'b1, -1);
    end else begin
      push_rsp(32'hC0DE_0001, 1'b1, -1);
    end
    RSP_READY = 1'b0;
    issue(1'b0, 32'h1140_0000, 32'd0, 8'd1);
    wait_rsp_valid("rd_clkcnt");
    repeat (3) @(posedge CLK);
    #1 RSP_READY = 1'b1;
    wait_done("rd_clkcnt");

    // Four-beat write with grant withheld 5 cycles, then dropped 2 cycles; a stray command is ignored
    if (BURST) begin
      for (int i = 0; i < 4; i++) strb_q.push_back({32'h110C_0000 + 32'(4 * i), 32'h0000_0077});
    end else begin
      strb_q.push_back({32'h110C_0000, 32'h0000_0077});
    end
    push_rsp(32'd0, 1'b1, -1);
    BUS_GNT = 1'b0;
    issue(1'b1, 32'h110C_0000, 32'h0000_0077, 8'd3);
    CMD_VALID = 1'b1;
    CMD_WR    = 1'b1;
    CMD_ADDR  = 32'h1108_0000;
    CMD_WDATA = 32'hDEAD_BEEF;
    repeat (5) @(posedge CLK);
    #1;
    BUS_GNT   = 1'b1;
    CMD_VALID = 1'b0;
    repeat (BURST ? 2 : 1) @(posedge CLK);
    #1 BUS_GNT = 1'b0;
    repeat (2) @(posedge CLK);
    #1 BUS_GNT = 1'b1;
    wait_done("wr_gnt");

    // Burst starting at the top of the address space wraps to 0
    if (BURST) begin
      push_rsp(32'h5A5A_5A59, 1'b0, 2);
      push_rsp(32'hA5A5_A5A5, 1'b1, -1);
    end else begin
      push_rsp(32'h5A5A_5A59, 1'b1, 2);
    end
    issue(1'b0, 32'hFFFF_FFFC, 32'd0, 8'd1);
    wait_done("rd_wrap");

    // Reset while beat 0 of a three-beat read is held in RSP; no response may escape
    RSP_READY = 1'b0;
    issue(1'b0, 32'h110C_0000, 32'd0, 8'd2);
    wait_rsp_valid("rd_reset");
    check("rd_reset_rdata_before", RSP_RDATA, 32'hB4A9_A5A5);
    @(posedge CLK);
    #3 RESET_N = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N   = 1'b1;
    RSP_READY = 1'b1;
    @(negedge CLK);
    check("post_reset_cmd_ready", CMD_READY, 1'b1);
    check("post_reset_no_rsp", RSP_VALID, 1'b0);

    // A fresh single read completes normally after reset
    push_rsp(32'hC0DE_0002, 1'b1, 2);
    issue(1'b0, 32'h1140_0004, 32'd0, 8'd0);
    wait_done("rd_after_reset");

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
